// File: rtl/ederah_stream_sender_pkg.sv
// Shared types and default widths for the ederah stream sender.
package ederah_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 512;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND_NFA   = 2'd1,
    SEND_QUERY = 2'd2
  } sender_state_t;

endpackage

// File: rtl/ederah_stream_sender_obuf.sv
// One-entry AXI-Stream output register: holds a beat until downstream
// accepts it and refills in the same cycle, so a continuous stream
// keeps one beat per clock.
module ederah_axis_obuf #(
  parameter int unsigned G_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  input  logic [G_WIDTH-1:0] in_data_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output logic [G_WIDTH-1:0] out_data_o,
  output logic               out_last_o,
  input  logic               out_ready_i
);

  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [G_WIDTH-1:0] data_q, data_d;

  // Load on upstream handshake, otherwise drain when downstream accepts.
  always_comb begin
    in_ready_o = ~valid_q | out_ready_i;
    valid_d    = valid_q;
    last_d     = last_q;
    data_d     = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      last_d  = in_last_i;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Register stage; reset drops valid immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/ederah_stream_sender.sv
// Host-side transmitter for the engine inputs stream: per command, an
// optional NFA segment (only when the hash changes) then a query segment,
// each closed with tlast.
module ederah_stream_sender
  import ederah_stream_pkg::*;
#(
  parameter int unsigned G_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned G_CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                      data_clk,
  input  logic                      data_rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               cmd_nfa_hash,
  input  logic [G_CNT_WIDTH-1:0]    cmd_nfa_beats,
  input  logic [G_CNT_WIDTH-1:0]    cmd_query_beats,
  input  logic                      nfa_src_tvalid,
  output logic                      nfa_src_tready,
  input  logic [G_DATA_WIDTH-1:0]   nfa_src_tdata,
  input  logic                      qry_src_tvalid,
  output logic                      qry_src_tready,
  input  logic [G_DATA_WIDTH-1:0]   qry_src_tdata,
  output logic                      inputs_stream_tvalid,
  input  logic                      inputs_stream_tready,
  output logic [G_DATA_WIDTH-1:0]   inputs_stream_tdata,
  output logic [G_DATA_WIDTH/8-1:0] inputs_stream_tkeep,
  output logic                      inputs_stream_tlast,
  output logic                      nfa_sent_o,
  output logic                      done_o,
  output logic                      cmd_err_o
);

  sender_state_t            state_q, state_d;
  logic [G_CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [G_CNT_WIDTH-1:0]   qry_beats_q, qry_beats_d;
  logic [31:0]              last_hash_q, last_hash_d;
  logic                     cmd_err_q, cmd_err_d;
  logic                     rdy_en_q;

  logic                     obuf_in_ready;
  logic                     obuf_out_valid;
  logic                     obuf_out_last;
  logic                     obuf_out_is_nfa;
  logic [G_DATA_WIDTH-1:0]  obuf_out_data;

  logic                     src_valid;
  logic [G_DATA_WIDTH-1:0]  src_data;
  logic                     src_fire;
  logic                     seg_last;
  logic                     cmd_fire;
  logic                     reload;
  logic                     cmd_bad;
  logic [G_CNT_WIDTH-1:0]   rem_dec;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign reload   = (cmd_nfa_hash != last_hash_q);
  assign cmd_bad  = (reload && (cmd_nfa_beats == '0)) || (cmd_query_beats == '0);
  assign seg_last = (rem_q == G_CNT_WIDTH'(1));
  assign rem_dec  = (rem_q != '0) ? rem_q - G_CNT_WIDTH'(1) : '0;
  assign src_fire = src_valid & obuf_in_ready;

  // State register.
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state and segment bookkeeping.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    qry_beats_d = qry_beats_q;
    last_hash_d = last_hash_q;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else if (reload) begin
            last_hash_d = cmd_nfa_hash;
            rem_d       = cmd_nfa_beats;
            qry_beats_d = cmd_query_beats;
            state_d     = SEND_NFA;
          end else begin
            rem_d   = cmd_query_beats;
            state_d = SEND_QUERY;
          end
        end
      end
      SEND_NFA: begin
        if (src_fire) begin
          if (seg_last) begin
            rem_d   = qry_beats_q;
            state_d = SEND_QUERY;
          end else begin
            rem_d = rem_dec;
          end
        end
      end
      SEND_QUERY: begin
        if (src_fire) begin
          rem_d = rem_dec;
          if (seg_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: source mux, handshakes and completion pulses.
  always_comb begin
    cmd_ready      = (state_q == IDLE) & ~obuf_out_valid & rdy_en_q;
    nfa_src_tready = (state_q == SEND_NFA) & obuf_in_ready;
    qry_src_tready = (state_q == SEND_QUERY) & obuf_in_ready;
    src_valid      = 1'b0;
    src_data       = qry_src_tdata;
    if (state_q == SEND_NFA) begin
      src_valid = nfa_src_tvalid;
      src_data  = nfa_src_tdata;
    end else if (state_q == SEND_QUERY) begin
      src_valid = qry_src_tvalid;
    end
    nfa_sent_o = obuf_out_valid & inputs_stream_tready & obuf_out_last & obuf_out_is_nfa;
    done_o     = obuf_out_valid & inputs_stream_tready & obuf_out_last & ~obuf_out_is_nfa;
  end

  // Datapath registers; rdy_en_q keeps cmd_ready low until the first edge after reset.
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      rem_q       <= '0;
      qry_beats_q <= '0;
      last_hash_q <= '0;
      cmd_err_q   <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      qry_beats_q <= qry_beats_d;
      last_hash_q <= last_hash_d;
      cmd_err_q   <= cmd_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // The segment tag rides alongside the data so the pulses know which segment closed.
  ederah_axis_obuf #(
    .G_WIDTH(G_DATA_WIDTH + 1)
  ) u_obuf (
    .clk_i       (data_clk),
    .rst_ni      (data_rst_n),
    .in_valid_i  (src_valid),
    .in_data_i   ({(state_q == SEND_NFA), src_data}),
    .in_last_i   (seg_last),
    .in_ready_o  (obuf_in_ready),
    .out_valid_o (obuf_out_valid),
    .out_data_o  ({obuf_out_is_nfa, obuf_out_data}),
    .out_last_o  (obuf_out_last),
    .out_ready_i (inputs_stream_tready)
  );

  assign inputs_stream_tvalid = obuf_out_valid;
  assign inputs_stream_tdata  = obuf_out_data;
  assign inputs_stream_tlast  = obuf_out_last;
  assign inputs_stream_tkeep  = '1;
  assign cmd_err_o            = cmd_err_q;

endmodule
